// File: rtl/tm1638_driver_gen.sv
`default_nettype none
// ============================================================================
// Module   : tm1638_driver_gen
// Brief    : Streams complete TM1638 frames into an SPI TX FIFO, one byte/cycle
// Revision : 1.0
// ============================================================================
module tm1638_driver_gen #(
   parameter int NUM_GRIDS      = 8,
   parameter int ADDR_MODE      = 0,
   parameter int SKIP_UNCHANGED = 1
) (
   input  logic                   i_Clk,
   input  logic                   i_Rst,
   input  logic [NUM_GRIDS*8-1:0] i_Segments,
   input  logic [NUM_GRIDS-1:0]   i_Leds,
   input  logic [2:0]             i_Brightness,
   input  logic                   i_Display_On,
   input  logic                   i_Valid,
   input  logic                   i_SPI_FIFO_Full,
   output logic [16:0]            o_Data,
   output logic                   o_Write,
   output logic                   o_Busy,
   output logic [2:0]             o_Diag_State
);

   localparam int c_SEG_W     = NUM_GRIDS * 8;
   localparam int c_FRAME_W   = c_SEG_W + NUM_GRIDS + 4;
   localparam int c_NUM_BYTES = 2 * NUM_GRIDS;
   localparam int c_IDX_W     = $clog2(c_NUM_BYTES);
   localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(c_NUM_BYTES - 1);
   localparam logic [7:0] c_MODE_CMD = (ADDR_MODE == 1) ? 8'h44 : 8'h40;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_MODE = 3'd1,
      ST_ADDR = 3'd2,
      ST_DATA = 3'd3,
      ST_CTRL = 3'd4
   } state_t;

   // Frame layout: {on, brightness[2:0], leds, segments}
   state_t                 r_state,      w_state_nxt;
   logic [c_IDX_W-1:0]     r_idx,        w_idx_nxt;
   logic [c_FRAME_W-1:0]   r_shadow,     w_shadow_nxt;
   logic [c_FRAME_W-1:0]   r_pending,    w_pending_nxt;
   logic                   r_pend_valid, w_pend_valid_nxt;
   logic [c_FRAME_W-1:0]   r_last,       w_last_nxt;
   logic                   r_last_valid, w_last_valid_nxt;

   logic [c_FRAME_W-1:0]   w_in_frame;
   logic [7:0]             w_byte;
   logic [7:0]             w_ctrl_byte;
   logic                   w_write;

   assign w_in_frame  = {i_Display_On, i_Brightness, i_Leds, i_Segments};
   assign w_ctrl_byte = {4'b1000, r_shadow[c_FRAME_W-1], r_shadow[c_SEG_W+NUM_GRIDS +: 3]};
   assign w_write     = (r_state != ST_IDLE) && !i_SPI_FIFO_Full;

   // Even index selects a segment byte, odd index the matching LED bit
   always_comb begin
      w_byte = 8'h00;
      for (int g = 0; g < NUM_GRIDS; g++) begin
         if ((int'(r_idx) >> 1) == g) begin
            w_byte = r_idx[0] ? {7'b0, r_shadow[c_SEG_W + g]} : r_shadow[g*8 +: 8];
         end
      end
   end

   always_ff @(posedge i_Clk) begin
      if (i_Rst) begin
         r_state      <= ST_IDLE;
         r_idx        <= '0;
         r_shadow     <= '0;
         r_pending    <= '0;
         r_pend_valid <= 1'b0;
         r_last       <= '0;
         r_last_valid <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_idx        <= w_idx_nxt;
         r_shadow     <= w_shadow_nxt;
         r_pending    <= w_pending_nxt;
         r_pend_valid <= w_pend_valid_nxt;
         r_last       <= w_last_nxt;
         r_last_valid <= w_last_valid_nxt;
      end
   end

   always_comb begin
      w_state_nxt      = r_state;
      w_idx_nxt        = r_idx;
      w_shadow_nxt     = r_shadow;
      w_pending_nxt    = r_pending;
      w_pend_valid_nxt = r_pend_valid;
      w_last_nxt       = r_last;
      w_last_valid_nxt = r_last_valid;
      o_Data           = 17'h0_0000;

      // Requests arriving mid-frame coalesce into one pending slot
      if ((r_state != ST_IDLE) && i_Valid) begin
         w_pending_nxt    = w_in_frame;
         w_pend_valid_nxt = 1'b1;
      end

      case (r_state)
         ST_IDLE: begin
            if (i_Valid) begin
               w_shadow_nxt = w_in_frame;
               if (!((SKIP_UNCHANGED != 0) && r_last_valid && (w_in_frame == r_last))) begin
                  w_state_nxt = ST_MODE;
               end
            end
         end
         ST_MODE: begin
            o_Data = {1'b1, 8'h00, c_MODE_CMD};
            if (w_write) begin
               w_state_nxt = ST_ADDR;
               w_idx_nxt   = '0;
            end
         end
         ST_ADDR: begin
            o_Data = {1'b1, 8'h00, (ADDR_MODE == 1) ? (8'hC0 | 8'(r_idx)) : 8'hC0};
            if (w_write) begin
               w_state_nxt = ST_DATA;
            end
         end
         ST_DATA: begin
            o_Data = {1'b0, 8'h00, w_byte};
            if (w_write) begin
               if (r_idx == c_LAST_IDX) begin
                  w_state_nxt = ST_CTRL;
               end else begin
                  w_idx_nxt   = r_idx + c_IDX_W'(1);
                  w_state_nxt = (ADDR_MODE == 1) ? ST_ADDR : ST_DATA;
               end
            end
         end
         ST_CTRL: begin
            o_Data = {1'b1, 8'h00, w_ctrl_byte};
            if (w_write) begin
               w_last_nxt       = r_shadow;
               w_last_valid_nxt = 1'b1;
               w_state_nxt      = ST_IDLE;
               // Promotion compares against the frame that just became last-sent
               if (w_pend_valid_nxt) begin
                  w_pend_valid_nxt = 1'b0;
                  if (!((SKIP_UNCHANGED != 0) && (w_pending_nxt == r_shadow))) begin
                     w_shadow_nxt = w_pending_nxt;
                     w_state_nxt  = ST_MODE;
                  end
               end
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   assign o_Write      = w_write;
   assign o_Busy       = (r_state != ST_IDLE);
   assign o_Diag_State = r_state;

endmodule
`default_nettype wire

// File: tb/tb_tm1638_driver_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_tm1638_driver_gen
// Brief    : Directed self-checking bench for tm1638_driver_gen (two configs)
// Revision : 1.0
// ============================================================================
module tb_tm1638_driver_gen;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [63:0] seg = '0;
   logic [7:0]  led = '0;
   logic [2:0]  bri = '0;
   logic        on  = 1'b0;
   logic        vld = 1'b0;
   logic        full = 1'b0;
   logic [16:0] data;
   logic        wr, busy;
   logic [2:0]  diag;

   logic [15:0] seg1 = '0;
   logic [1:0]  led1 = '0;
   logic [2:0]  bri1 = '0;
   logic        on1  = 1'b0;
   logic        vld1 = 1'b0;
   logic        full1 = 1'b0;
   logic [16:0] data1;
   logic        wr1, busy1;
   logic [2:0]  diag1;

   int          total = 0;
   int          bad   = 0;
   int          cyc   = 0;
   int          t_valid = 0;
   logic        saw_busy = 1'b0;
   logic [16:0] q[$];
   int          qc[$];
   logic [16:0] q1[$];
   logic [16:0] exp_q[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   tm1638_driver_gen #(.NUM_GRIDS(8), .ADDR_MODE(0), .SKIP_UNCHANGED(1)) dut (
      .i_Clk(clk), .i_Rst(rst), .i_Segments(seg), .i_Leds(led), .i_Brightness(bri),
      .i_Display_On(on), .i_Valid(vld), .i_SPI_FIFO_Full(full),
      .o_Data(data), .o_Write(wr), .o_Busy(busy), .o_Diag_State(diag)
   );

   tm1638_driver_gen #(.NUM_GRIDS(2), .ADDR_MODE(1), .SKIP_UNCHANGED(1)) dut1 (
      .i_Clk(clk), .i_Rst(rst), .i_Segments(seg1), .i_Leds(led1), .i_Brightness(bri1),
      .i_Display_On(on1), .i_Valid(vld1), .i_SPI_FIFO_Full(full1),
      .o_Data(data1), .o_Write(wr1), .o_Busy(busy1), .o_Diag_State(diag1)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Write capture plus the no-write-while-full rule, sampled mid-cycle
   always @(negedge clk) begin
      if (wr === 1'b1) begin
         q.push_back(data);
         qc.push_back(cyc);
      end
      if (wr1 === 1'b1) q1.push_back(data1);
      if (busy === 1'b1) saw_busy = 1'b1;
      if (full) chk("no_write_while_full", 32'(wr), 32'd0);
   end

   initial begin
      #200000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "global timeout");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse8(input logic [63:0] s, input logic [7:0] l, input logic [2:0] b, input logic o);
      seg = s; led = l; bri = b; on = o; vld = 1'b1;
      t_valid = cyc;
      step();
      vld = 1'b0;
   endtask

   task automatic wait_idle(input string tag, input int budget);
      int n;
      n = 0;
      while (busy && n < budget) begin
         step();
         n++;
      end
      chk({tag, "_timeout"}, 32'(n >= budget), 32'd0);
   endtask

   task automatic cmp_stream(input string tag, input logic [16:0] got[$]);
      chk({tag, "_len"}, 32'(got.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < got.size(); i++)
         chk($sformatf("%s_b%0d", tag, i), 32'(got[i]), 32'(exp_q[i]));
   endtask

   // segs 3F everywhere, LEDs 0x55 -> odd bytes 01,00 alternating
   task automatic exp_a(input logic [7:0] ctrl);
      exp_q.push_back(17'h1_0040);
      exp_q.push_back(17'h1_00C0);
      for (int i = 0; i < 4; i++) begin
         exp_q.push_back(17'h0_003F); exp_q.push_back(17'h0_0001);
         exp_q.push_back(17'h0_003F); exp_q.push_back(17'h0_0000);
      end
      exp_q.push_back({9'h100, ctrl});
   endtask

   // segs 11..88 per grid, LEDs 0x0F, brightness 2, display off -> 0x82
   task automatic exp_b();
      logic [7:0] sb [8];
      sb[0] = 8'h11; sb[1] = 8'h22; sb[2] = 8'h33; sb[3] = 8'h44;
      sb[4] = 8'h55; sb[5] = 8'h66; sb[6] = 8'h77; sb[7] = 8'h88;
      exp_q.push_back(17'h1_0040);
      exp_q.push_back(17'h1_00C0);
      for (int g = 0; g < 8; g++) begin
         exp_q.push_back({9'h000, sb[g]});
         exp_q.push_back((g < 4) ? 17'h0_0001 : 17'h0_0000);
      end
      exp_q.push_back(17'h1_0082);
   endtask

   // all-zero segments/LEDs, brightness 5, on -> 0x8D
   task automatic exp_c3();
      exp_q.push_back(17'h1_0040);
      exp_q.push_back(17'h1_00C0);
      for (int i = 0; i < 16; i++) exp_q.push_back(17'h0_0000);
      exp_q.push_back(17'h1_008D);
   endtask

   localparam logic [63:0] SEG_A = 64'h3F3F3F3F3F3F3F3F;
   localparam logic [63:0] SEG_B = 64'h8877665544332211;

   initial begin
      int n;
      int hold;

      // Reset state
      repeat (3) step();
      chk("rst_write", 32'(wr), 32'd0);
      chk("rst_data", 32'(data), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_diag", 32'(diag), 32'd0);
      chk("rst_write1", 32'(wr1), 32'd0);
      rst = 1'b0;
      step();

      // Unstalled frame: 19 back-to-back writes, first one cycle after i_Valid
      q.delete(); qc.delete(); exp_q.delete();
      pulse8(SEG_A, 8'h55, 3'd7, 1'b1);
      chk("a_busy", 32'(busy), 32'd1);
      wait_idle("a", 100);
      exp_a(8'h8F);
      cmp_stream("a", q);
      chk("a_latency", (qc.size() > 0) ? 32'(qc[0]) : 32'hFFFF_FFFF, 32'(t_valid + 1));
      chk("a_contig", (qc.size() == 19) ? 32'(qc[18] - qc[0]) : 32'hFFFF_FFFF, 32'd18);

      // Identical request is dropped: no writes, never busy
      q.delete(); saw_busy = 1'b0;
      pulse8(SEG_A, 8'h55, 3'd7, 1'b1);
      repeat (20) step();
      chk("skip_len", 32'(q.size()), 32'd0);
      chk("skip_busy", 32'(saw_busy), 32'd0);

      // Brightness-only change resends the whole frame
      q.delete(); exp_q.delete();
      pulse8(SEG_A, 8'h55, 3'd3, 1'b1);
      wait_idle("bri", 100);
      exp_a(8'h8B);
      cmp_stream("bri", q);

      // FIFO back-pressure toggling every 2..12 cycles
      q.delete(); exp_q.delete();
      pulse8(SEG_B, 8'h0F, 3'd2, 1'b0);
      n = 0; hold = 0;
      while (busy && n < 2000) begin
         if (hold == 0) begin
            full = ~full;
            hold = $urandom_range(2, 12);
         end
         hold--;
         step();
         n++;
      end
      full = 1'b0;
      chk("stall_timeout", 32'(n >= 2000), 32'd0);
      exp_b();
      cmp_stream("stall", q);

      // Three requests during one frame coalesce into one follow-up (the last)
      q.delete(); qc.delete(); exp_q.delete();
      pulse8(SEG_A, 8'h55, 3'd7, 1'b1);
      step();
      pulse8({8{8'hFF}}, 8'hFF, 3'd1, 1'b1);
      step();
      pulse8(64'h0, 8'hFF, 3'd0, 1'b0);
      step();
      pulse8(64'h0, 8'h00, 3'd5, 1'b1);
      wait_idle("coal", 200);
      exp_a(8'h8F);
      exp_c3();
      cmp_stream("coal", q);
      chk("coal_contig", (qc.size() == 38) ? 32'(qc[37] - qc[0]) : 32'hFFFF_FFFF, 32'd37);

      // Reset after the 5th write, with a pending request that must be discarded
      q.delete(); exp_q.delete();
      pulse8(SEG_B, 8'h0F, 3'd2, 1'b0);
      step();
      pulse8(SEG_A, 8'h55, 3'd7, 1'b1);
      n = 0;
      while (q.size() < 5 && n < 50) begin
         @(negedge clk);
         #1;
         n++;
      end
      chk("mid_reach5", 32'(q.size()), 32'd5);
      rst = 1'b1;
      step();
      chk("mid_rst_write", 32'(wr), 32'd0);
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_diag", 32'(diag), 32'd0);
      rst = 1'b0;
      repeat (10) step();
      chk("mid_no_more_writes", 32'(q.size()), 32'd5);
      q.delete();
      pulse8(SEG_B, 8'h0F, 3'd2, 1'b0);
      wait_idle("after_rst", 100);
      exp_b();
      cmp_stream("after_rst", q);

      // Fixed-address config, 2 grids: grid0=A5 led0=0, grid1=B6 led1=1, ctrl 0x8C
      q1.delete(); exp_q.delete();
      seg1 = 16'hB6A5; led1 = 2'b10; bri1 = 3'd4; on1 = 1'b1; vld1 = 1'b1;
      step();
      vld1 = 1'b0;
      n = 0;
      while (busy1 && n < 100) begin
         step();
         n++;
      end
      chk("fixed_timeout", 32'(n >= 100), 32'd0);
      exp_q.push_back(17'h1_0044); exp_q.push_back(17'h1_00C0);
      exp_q.push_back(17'h0_00A5); exp_q.push_back(17'h1_00C1);
      exp_q.push_back(17'h0_0000); exp_q.push_back(17'h1_00C2);
      exp_q.push_back(17'h0_00B6); exp_q.push_back(17'h1_00C3);
      exp_q.push_back(17'h0_0001); exp_q.push_back(17'h1_008C);
      cmp_stream("fixed", q1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
